z_hilo_sequencer: RTL

Result-writeback stage directly downstream of the ALU's 64-bit producers: the divider and the multiplier. It accepts one 64-bit ALU result per handshake, latches it into the ZHI/ZLO pair, and drives the words onto the 32-bit internal bus one at a time. Wide ops (mul/div) write LO then HI; narrow ops write only ZLO to the destination register (Rz). It also reports N/Z condition flags and aborts cleanly if the bus is never granted.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/reg32.sv | 19 +
 rtl/z_hilo_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: internal-bus destination codes and the ZHI/ZLO
// writeback sequencer state encoding.
package cpu_pkg;

    // Destination tags carried alongside each word on the internal bus
    localparam logic [1:0] DEST_RZ = 2'b00;
    localparam logic [1:0] DEST_LO = 2'b01;
    localparam logic [1:0] DEST_HI = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE_LO = 2'b01,
        DRIVE_HI = 2'b10
    } zseq_state_t;

endpackage

// File: rtl/reg32.sv
// 32-bit load-enable register with synchronous active-high clear.
module reg32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Clear wins over load; otherwise hold unless enabled
    always_ff @(posedge clock) begin
        if (clear) begin
            q <= 32'd0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/z_hilo_sequencer.sv
// Writeback stage for 64-bit ALU results: latches the result into ZHI/ZLO and
// drives it onto the 32-bit bus (LO then HI for wide ops, Rz only for narrow
// ops). Aborts with timeout_err when a word waits GRANT_TIMEOUT cycles.
module z_hilo_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned GRANT_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic        in_wide,
    input  logic        bus_grant,
    output logic        bus_drive,
    output logic [31:0] bus_out,
    output logic [1:0]  bus_dest,
    output logic        done,
    output logic        timeout_err,
    output logic        flag_n,
    output logic        flag_z
);

    localparam int unsigned CntW = $clog2(GRANT_TIMEOUT + 1);
    // Abort on the ungranted cycle that would bring the count to GRANT_TIMEOUT,
    // so the counter never needs to hold more than GRANT_TIMEOUT-1
    localparam logic [CntW-1:0] CntLast = CntW'(GRANT_TIMEOUT - 1);

    zseq_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wide_q, wide_d;
    logic            flag_n_q, flag_n_d;
    logic            flag_z_q, flag_z_d;
    logic            done_q, done_d;
    logic            tmo_q, tmo_d;
    logic            load;
    logic [31:0]     zhi, zlo;

    reg32 u_zhi (
        .clock (clock),
        .clear (clear),
        .en    (load),
        .d     (in_result[63:32]),
        .q     (zhi)
    );

    reg32 u_zlo (
        .clock (clock),
        .clear (clear),
        .en    (load),
        .d     (in_result[31:0]),
        .q     (zlo)
    );

    // State, counter, flags and registered pulses
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wide_q   <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wide_q   <= wide_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state: accept in IDLE, advance on grant, abort on expired wait
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wide_d   = wide_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    wide_d  = in_wide;
                    cnt_d   = '0;
                    state_d = DRIVE_LO;
                    if (in_wide) begin
                        flag_n_d = in_result[63];
                        flag_z_d = (in_result == 64'd0);
                    end else begin
                        flag_n_d = in_result[31];
                        flag_z_d = (in_result[31:0] == 32'd0);
                    end
                end
            end
            DRIVE_LO, DRIVE_HI: begin
                // Grant is checked first so it wins over a coincident timeout
                if (bus_grant) begin
                    cnt_d = '0;
                    if (state_q == DRIVE_LO && wide_q) begin
                        state_d = DRIVE_HI;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        in_ready  = 1'b0;
        bus_drive = 1'b0;
        bus_out   = 32'd0;
        bus_dest  = DEST_RZ;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            DRIVE_LO: begin
                bus_drive = 1'b1;
                bus_out   = zlo;
                bus_dest  = wide_q ? DEST_LO : DEST_RZ;
            end
            DRIVE_HI: begin
                bus_drive = 1'b1;
                bus_out   = zhi;
                bus_dest  = DEST_HI;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;

endmodule
